spi_xfer_sequencer: RTL and testbench

Master-side transfer sequencer for the SPI interface. It sits between the sender/receiver buffer handshakes and the SPI pins. It accepts bytes from the sender side, frames them with CS, and generates SCLK from a programmable divider. It shifts MOSI and samples MISO in all four CPOL/CPHA modes, then delivers each received byte to the receiver side with overrun detection. Consecutive bytes that are presented on time are sent as one burst under a single CS assertion.

---
 rtl/spi_xfer_sequencer.sv | 127 ++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer.sv
// SPI master transfer sequencer: frames bytes with CS, divides SCLK, shifts MOSI/MISO
// in all four CPOL/CPHA modes and hands each received byte downstream with overrun detection.
module spi_xfer_sequencer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              ENABLE,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic [DIV_W-1:0]  DIV,
    input  logic              TX_VALID,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_READY,
    output logic              RX_VALID,
    output logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_READY,
    output logic              RX_OVERRUN,
    input  logic              OVR_CLR,
    output logic              BUSY,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              CS
);
    localparam int EDGES  = 2 * DATA_W;
    localparam int BCNT_W = $clog2(EDGES) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t state, state_next;

    logic [DIV_W-1:0]  hcnt, div_q;
    logic [BCNT_W-1:0] edge_cnt, edge_next;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q;
    logic              cpha_q, cpha_eff, sclk_q, mosi_q, rx_valid_q, ovr_q;
    logic              half_done, accept, do_edge, sample_phase, edge_sample, edge_drive, push;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        half_done    = (hcnt == div_q);
        edge_next    = edge_cnt + BCNT_W'(1);
        TX_READY     = ENABLE && !CLR && ((state == IDLE) || (state == HOLD && half_done));
        accept       = TX_VALID && TX_READY;
        cpha_eff     = (state == IDLE) ? CPHA : cpha_q;
        do_edge      = half_done && (state == SETUP || state == SHIFT);
        // Odd edges sample when CPHA=0, even edges sample when CPHA=1.
        sample_phase = edge_next[0] ^ cpha_q;
        edge_sample  = do_edge && sample_phase;
        edge_drive   = do_edge && !sample_phase && (edge_next != BCNT_W'(EDGES));
        push         = (state == HOLD) && half_done;
        state_next   = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   if (half_done) state_next = SHIFT;
            SHIFT:   if (half_done && edge_next == BCNT_W'(EDGES)) state_next = HOLD;
            HOLD:    if (half_done) state_next = accept ? SETUP : GAP;
            GAP:     if (half_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        CS       = !(state == SETUP || state == SHIFT || state == HOLD);
        BUSY     = (state != IDLE);
        SCLK     = sclk_q;
        MOSI     = mosi_q;
        RX_VALID = rx_valid_q;
        RX_DATA  = rx_data_q;
        RX_OVERRUN = ovr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            hcnt       <= '0;
            div_q      <= '0;
            edge_cnt   <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            hcnt <= (state == IDLE || half_done) ? '0 : hcnt + DIV_W'(1);
            if (state == IDLE) sclk_q <= CPOL;

            if (accept) begin
                div_q    <= DIV;
                edge_cnt <= '0;
                if (state == IDLE) cpha_q <= CPHA;
                // CPHA=0 needs the MSB on MOSI before the first (sampling) edge.
                if (cpha_eff) begin
                    tx_sr <= TX_DATA;
                end else begin
                    mosi_q <= TX_DATA[DATA_W-1];
                    tx_sr  <= TX_DATA << 1;
                end
            end

            if (do_edge) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_next;
            end
            if (edge_sample) rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            if (edge_drive) begin
                mosi_q <= tx_sr[DATA_W-1];
                tx_sr  <= tx_sr << 1;
            end

            if (push && (!rx_valid_q || RX_READY)) begin
                rx_data_q  <= rx_sr;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && RX_READY) begin
                rx_valid_q <= 1'b0;
            end
            // A new overrun beats a simultaneous clear.
            if (push && rx_valid_q && !RX_READY) ovr_q <= 1'b1;
            else if (OVR_CLR)                    ovr_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: a scoreboard monitor checks delivered bytes,
// an SCLK-edge monitor plays the slave and checks MOSI, tasks check framing and timing.
module tb_spi_xfer_sequencer;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int EDGES  = 2 * DATA_W;

    logic              CLK = 1'b0;
    logic              CLR, ENABLE, CPOL, CPHA, TX_VALID, RX_READY, OVR_CLR;
    logic [DIV_W-1:0]  DIV;
    logic [DATA_W-1:0] TX_DATA, RX_DATA;
    logic              TX_READY, RX_VALID, RX_OVERRUN, BUSY, SCLK, MOSI, MISO, CS;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic              loopback  = 1'b1;
    logic              chk_mosi  = 1'b0;
    logic              slave_bit = 1'b0;
    logic [DATA_W-1:0] slave_sr  = '0;
    logic [DATA_W-1:0] slave_byte = '0;
    logic [DATA_W-1:0] exp_tx    = '0;
    int                edge_total = 0;
    int                edge_in_byte = 0;
    logic              sclk_prev = 1'b0, mosi_prev = 1'b0, cs_prev = 1'b1, odd_edge;

    assign MISO = loopback ? MOSI : slave_bit;

    spi_xfer_sequencer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .CLK(CLK), .CLR(CLR), .ENABLE(ENABLE), .CPOL(CPOL), .CPHA(CPHA), .DIV(DIV),
        .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_READY(RX_READY),
        .RX_OVERRUN(RX_OVERRUN), .OVR_CLR(OVR_CLR), .BUSY(BUSY),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS(CS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every byte the DUT hands over is compared with the next expectation.
    always @(negedge CLK) begin
        if (RX_VALID === 1'b1 && RX_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no byte", RX_DATA);
            end else begin
                check("rx_data", RX_DATA, exp_q.pop_front());
            end
        end
    end

    // SCLK edge monitor and slave model; edges are counted only while CS is low.
    always @(negedge CLK) begin
        if (CS !== 1'b0) begin
            edge_in_byte = 0;
        end else begin
            if (cs_prev === 1'b1) begin
                slave_sr = slave_byte;
                if (!CPHA) begin
                    slave_bit = slave_sr[DATA_W-1];
                    slave_sr  = slave_sr << 1;
                end
            end
            if (SCLK !== sclk_prev) begin
                edge_in_byte = edge_in_byte % EDGES + 1;
                edge_total++;
                odd_edge = ((edge_in_byte % 2) == 1);
                if (odd_edge != CPHA) begin
                    if (chk_mosi) begin
                        check("mosi_stable", MOSI, mosi_prev);
                        check("mosi_bit", MOSI, exp_tx[DATA_W-1-(edge_in_byte-1)/2]);
                    end
                end else if (edge_in_byte != EDGES) begin
                    slave_bit = slave_sr[DATA_W-1];
                    slave_sr  = slave_sr << 1;
                end
            end
        end
        sclk_prev = SCLK;
        mosi_prev = MOSI;
        cs_prev   = CS;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents a byte and returns in cycle 1 of its transfer (the cycle after accept).
    task automatic send_byte(input logic [DATA_W-1:0] d, input bit expect_rx, input logic [DATA_W-1:0] rx);
        int n = 0;
        TX_DATA  = d;
        TX_VALID = 1'b1;
        while (TX_READY !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("accept_ready", TX_READY, 1);
        if (expect_rx) exp_q.push_back(rx);
        tick();
        TX_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check("idle_reached", BUSY, 0);
    endtask

    // Accept at cycle 0: RX_VALID and CS rise at 1+(2*DATA_W+1)H, TX_READY returns at 1+(2*DATA_W+2)H.
    task automatic timed_byte(input string name, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rx,
                              input int div, input logic cpol, input logic cpha);
        int h, cyc, cs_low;
        h = div + 1;
        DIV  = DIV_W'(div);
        CPOL = cpol;
        CPHA = cpha;
        tick();
        tick();
        check({name, "_sclk_idle"}, SCLK, cpol);
        edge_total = 0;
        send_byte(d, 1'b1, rx);
        cyc    = 1;
        cs_low = 0;
        while (RX_VALID !== 1'b1 && cyc < 2000) begin
            if (CS === 1'b0) cs_low++;
            tick();
            cyc++;
        end
        check({name, "_rx_cycle"}, cyc, 1 + (EDGES + 1) * h);
        check({name, "_cs_low_cycles"}, cs_low, (EDGES + 1) * h);
        check({name, "_cs_rise"}, CS, 1);
        check({name, "_edges"}, edge_total, EDGES);
        repeat (h) tick();
        check({name, "_ready_again"}, TX_READY, 1);
        check({name, "_busy_low"}, BUSY, 0);
        check({name, "_sclk_end"}, SCLK, cpol);
    endtask

    task automatic burst_test();
        logic [DATA_W-1:0] bytes [3];
        int idx = 0, pushes = 0, n = 0, viol = 0;
        int push_cyc [3];
        bit acc, started = 0;
        bytes[0] = 8'h11;
        bytes[1] = 8'h22;
        bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
        DIV      = 8'd1;
        TX_DATA  = bytes[0];
        TX_VALID = 1'b1;
        while (pushes < 3 && n < 3000) begin
            acc = TX_VALID && TX_READY;
            tick();
            n++;
            if (acc) begin
                started = 1;
                idx++;
                if (idx < 3) TX_DATA = bytes[idx];
                else         TX_VALID = 1'b0;
            end
            if (RX_VALID === 1'b1) begin
                push_cyc[pushes] = n;
                pushes++;
            end
            if (started && pushes < 3 && (CS !== 1'b0 || BUSY !== 1'b1)) viol++;
        end
        TX_VALID = 1'b0;
        check("burst_pushes", pushes, 3);
        check("burst_cs_busy_violations", viol, 0);
        check("burst_period_1", push_cyc[1] - push_cyc[0], (EDGES + 1) * 2);
        check("burst_period_2", push_cyc[2] - push_cyc[1], (EDGES + 1) * 2);
        check("burst_end_cs", CS, 1);
        wait_idle();
    endtask

    initial begin
        CLR = 1'b1;  ENABLE = 1'b1; CPOL = 1'b0; CPHA = 1'b0; DIV = '0;
        TX_VALID = 1'b0; TX_DATA = '0; RX_READY = 1'b1; OVR_CLR = 1'b0;
        #12;
        check("rst_cs", CS, 1);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_tx_ready", TX_READY, 0);
        check("rst_rx_valid", RX_VALID, 0);
        check("rst_rx_data", RX_DATA, 0);
        check("rst_overrun", RX_OVERRUN, 0);
        check("rst_busy", BUSY, 0);
        @(negedge CLK);
        CLR = 1'b0;
        tick();

        // Basic loopback byte at DIV=0.
        loopback = 1'b1; chk_mosi = 1'b1; exp_tx = 8'hA5;
        timed_byte("basic", 8'hA5, 8'hA5, 0, 1'b0, 1'b0);

        // All four modes against a slave returning 0xC3.
        loopback = 1'b0; exp_tx = 8'h3C; slave_byte = 8'hC3;
        for (int m = 0; m < 4; m++)
            timed_byte($sformatf("mode%0d", m), 8'h3C, 8'hC3, 2, m[1], m[0]);
        CPOL = 1'b0; CPHA = 1'b0;
        tick();

        // Burst of three bytes under one CS assertion.
        loopback = 1'b1; chk_mosi = 1'b0;
        burst_test();

        // Overrun: second byte dropped while the first is unread.
        DIV = '0; RX_READY = 1'b0;
        send_byte(8'h55, 1'b1, 8'h55);
        wait_idle();
        check("ovr_first_valid", RX_VALID, 1);
        check("ovr_not_yet", RX_OVERRUN, 0);
        send_byte(8'hAA, 1'b0, 8'h00);
        wait_idle();
        check("ovr_data_kept", RX_DATA, 8'h55);
        check("ovr_flag", RX_OVERRUN, 1);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        check("ovr_cleared", RX_OVERRUN, 0);
        RX_READY = 1'b1;
        tick();
        tick();
        check("ovr_drained", RX_VALID, 0);

        // ENABLE drop mid-byte with TX_VALID still asserted.
        begin
            int n = 0, ready_seen = 0;
            DIV = 8'd1; edge_total = 0;
            exp_q.push_back(8'h5A);
            TX_DATA = 8'h5A; TX_VALID = 1'b1;
            while (TX_READY !== 1'b1 && n < 200) begin tick(); n++; end
            tick();
            n = 0;
            while (edge_total < 5 && n < 200) begin tick(); n++; end
            ENABLE = 1'b0;
            n = 0;
            while (BUSY !== 1'b0 && n < 2000) begin
                if (TX_READY !== 1'b0) ready_seen++;
                tick();
                n++;
            end
            check("endrop_idle", BUSY, 0);
            check("endrop_cs", CS, 1);
            repeat (20) begin
                if (TX_READY !== 1'b0 || BUSY !== 1'b0) ready_seen++;
                tick();
            end
            check("endrop_no_ready", ready_seen, 0);
            check("endrop_byte_done", exp_q.size(), 0);
            TX_VALID = 1'b0;
            ENABLE   = 1'b1;
        end

        // Asynchronous reset at the 7th edge, with an unread byte pending.
        begin
            int n = 0;
            RX_READY = 1'b0;
            send_byte(8'h0F, 1'b0, 8'h00);
            wait_idle();
            check("rstmid_pending", RX_VALID, 1);
            edge_total = 0;
            send_byte(8'h96, 1'b0, 8'h00);
            while (edge_total < 7 && n < 200) begin tick(); n++; end
            check("rstmid_sclk_high", SCLK, 1);
            #2;
            CLR = 1'b1;
            #1;
            check("rstmid_cs", CS, 1);
            check("rstmid_sclk", SCLK, 0);
            check("rstmid_busy", BUSY, 0);
            check("rstmid_rx_valid", RX_VALID, 0);
            @(negedge CLK);
            CLR      = 1'b0;
            RX_READY = 1'b1;
            tick();
            chk_mosi = 1'b1; exp_tx = 8'h3C;
            timed_byte("post_rst", 8'h3C, 8'h3C, 0, 1'b0, 1'b0);
        end

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
